board_cmd_arbiter: RTL and testbench

Sequencer that owns the single-port card-state RAM of the memory game and serializes all accesses to it. It accepts one-cycle flip/unflip/remove commands from the game FSM and level-held deal writes from the shuffle/deal engine, performs read-check-write on the addressed card, and holds each game command for a fixed animation window before acknowledging. It also counts removed cards and produces `all_pairs_done`.

---
 rtl/board_cmd_arbiter_if.sv | 49 ++++
 rtl/board_cmd_arbiter.sv | 233 +++++++++++++++++++++++
 tb/tb_board_cmd_arbiter.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/board_cmd_arbiter_if.sv
// Command, deal, card-RAM and status signals of the card-state arbiter.
interface board_cmd_arbiter_if;

   // game FSM side
   logic       req_flip;
   logic       req_unflip;
   logic       req_remove_pair;
   logic [3:0] act_idx;
   logic       flip_ack;
   logic       unflip_ack;
   logic       remove_ack;
   logic       op_reject;

   // deal engine side
   logic       deal_req;
   logic [3:0] deal_idx;
   logic [2:0] deal_sym;
   logic       deal_ack;

   // card-state RAM side
   logic [3:0] mem_addr;
   logic       mem_we;
   logic [4:0] mem_wdata;
   logic [4:0] mem_rdata;

   // status
   logic       anim_active;
   logic [3:0] anim_idx;
   logic       busy;
   logic       cmd_overflow;
   logic       all_pairs_done;

   modport slave (
      input  req_flip, req_unflip, req_remove_pair, act_idx,
             deal_req, deal_idx, deal_sym, mem_rdata,
      output flip_ack, unflip_ack, remove_ack, op_reject, deal_ack,
             mem_addr, mem_we, mem_wdata,
             anim_active, anim_idx, busy, cmd_overflow, all_pairs_done
   );

   modport master (
      output req_flip, req_unflip, req_remove_pair, act_idx,
             deal_req, deal_idx, deal_sym, mem_rdata,
      input  flip_ack, unflip_ack, remove_ack, op_reject, deal_ack,
             mem_addr, mem_we, mem_wdata,
             anim_active, anim_idx, busy, cmd_overflow, all_pairs_done
   );

endinterface

// File: rtl/board_cmd_arbiter.sv
// Serializes game commands and deal writes onto the single-port card-state RAM,
// holds each accepted game command for an animation window and counts removed cards.
module board_cmd_arbiter #(
   parameter int unsigned ANIM_CYCLES = 12_500_000,
   parameter int unsigned N_CARDS     = 16
) (
   input  logic               clk,
   input  logic               reset,
   board_cmd_arbiter_if.slave bus
);

   localparam int unsigned IDX_W  = 4;
   localparam int unsigned SYM_W  = 3;
   localparam int unsigned ST_W   = 2;
   localparam int unsigned WORD_W = ST_W + SYM_W;
   localparam int unsigned CNT_W  = 5;
   localparam int unsigned ANIM_W = (ANIM_CYCLES > 1) ? $clog2(ANIM_CYCLES) : 1;

   localparam logic [ST_W-1:0]   ST_HIDDEN  = ST_W'(0);
   localparam logic [ST_W-1:0]   ST_FACEUP  = ST_W'(1);
   localparam logic [ST_W-1:0]   ST_REMOVED = ST_W'(2);
   localparam logic [ANIM_W-1:0] ANIM_LAST  = ANIM_W'(ANIM_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(N_CARDS);

   typedef enum logic [2:0] {
      S_IDLE, S_DEAL, S_READ, S_EVAL, S_WRITE, S_ANIM, S_ACK
   } state_t;

   typedef enum logic [1:0] {
      OP_FLIP, OP_UNFLIP, OP_REMOVE, OP_DEAL
   } op_t;

   state_t              state_q,       state_nxt;
   op_t                 cur_op_q,      cur_op_nxt;
   logic [IDX_W-1:0]    cur_idx_q,     cur_idx_nxt;
   logic                reject_q,      reject_nxt;
   logic                pend_valid_q,  pend_valid_nxt;
   op_t                 pend_op_q,     pend_op_nxt;
   logic [IDX_W-1:0]    pend_idx_q,    pend_idx_nxt;
   logic [ANIM_W-1:0]   anim_cnt_q,    anim_cnt_nxt;
   logic [CNT_W-1:0]    removed_cnt_q, removed_cnt_nxt;
   logic                overflow_q,    overflow_nxt;

   logic                flip_ack_nxt, unflip_ack_nxt, remove_ack_nxt, deal_ack_nxt;
   logic                op_reject_nxt;
   logic [IDX_W-1:0]    mem_addr_nxt;
   logic                mem_we_nxt;
   logic [WORD_W-1:0]   mem_wdata_nxt;
   logic                anim_active_nxt;
   logic [IDX_W-1:0]    anim_idx_nxt;
   logic                busy_nxt;
   logic                all_pairs_nxt;

   logic                req_any, req_multi;
   logic [ST_W-1:0]     rd_st;
   logic                legal;
   logic [ST_W-1:0]     new_st;

   assign req_any   = bus.req_flip | bus.req_unflip | bus.req_remove_pair;
   assign req_multi = (bus.req_flip & bus.req_unflip) | (bus.req_flip & bus.req_remove_pair) |
                      (bus.req_unflip & bus.req_remove_pair);
   assign rd_st     = bus.mem_rdata[WORD_W-1:SYM_W];

   assign bus.cmd_overflow = overflow_q;

   // Status transition check for the command being evaluated.
   always_comb begin
      legal  = 1'b0;
      new_st = rd_st;
      case (cur_op_q)
         OP_FLIP:   begin legal = (rd_st == ST_HIDDEN); new_st = ST_FACEUP;  end
         OP_UNFLIP: begin legal = (rd_st == ST_FACEUP); new_st = ST_HIDDEN;  end
         OP_REMOVE: begin legal = (rd_st == ST_FACEUP); new_st = ST_REMOVED; end
         default:   begin legal = 1'b0;                 new_st = rd_st;      end
      endcase
   end

   // Next state, pending register, counters and next values of the registered outputs.
   always_comb begin
      state_nxt       = state_q;
      cur_op_nxt      = cur_op_q;
      cur_idx_nxt     = cur_idx_q;
      reject_nxt      = reject_q;
      pend_valid_nxt  = pend_valid_q;
      pend_op_nxt     = pend_op_q;
      pend_idx_nxt    = pend_idx_q;
      anim_cnt_nxt    = anim_cnt_q;
      removed_cnt_nxt = removed_cnt_q;
      overflow_nxt    = overflow_q;
      flip_ack_nxt    = 1'b0;
      unflip_ack_nxt  = 1'b0;
      remove_ack_nxt  = 1'b0;
      deal_ack_nxt    = 1'b0;
      op_reject_nxt   = 1'b0;
      mem_addr_nxt    = '0;
      mem_we_nxt      = 1'b0;
      mem_wdata_nxt   = '0;
      anim_active_nxt = 1'b0;
      anim_idx_nxt    = '0;

      // One-deep pending slot; a slot being read out this cycle counts as free.
      if (state_q == S_READ) pend_valid_nxt = 1'b0;
      if (req_any) begin
         if (!pend_valid_q || state_q == S_READ) begin
            pend_valid_nxt = 1'b1;
            pend_idx_nxt   = bus.act_idx;
            if (bus.req_remove_pair)  pend_op_nxt = OP_REMOVE;
            else if (bus.req_unflip)  pend_op_nxt = OP_UNFLIP;
            else                      pend_op_nxt = OP_FLIP;
            if (req_multi) overflow_nxt = 1'b1;
         end else begin
            overflow_nxt = 1'b1;
         end
      end

      case (state_q)
         S_IDLE: begin
            reject_nxt = 1'b0;
            if (bus.deal_req) begin
               state_nxt     = S_DEAL;
               cur_op_nxt    = OP_DEAL;
               cur_idx_nxt   = bus.deal_idx;
               mem_addr_nxt  = bus.deal_idx;
               mem_we_nxt    = 1'b1;
               mem_wdata_nxt = {ST_HIDDEN, bus.deal_sym};
            end else if (pend_valid_q) begin
               state_nxt    = S_READ;
               cur_op_nxt   = pend_op_q;
               cur_idx_nxt  = pend_idx_q;
               mem_addr_nxt = pend_idx_q;
            end
         end
         S_DEAL: begin
            state_nxt = S_ACK;
            if (cur_idx_q == '0) removed_cnt_nxt = '0;
         end
         S_READ: state_nxt = S_EVAL;
         S_EVAL: begin
            if (legal) begin
               state_nxt     = S_WRITE;
               mem_addr_nxt  = cur_idx_q;
               mem_we_nxt    = 1'b1;
               mem_wdata_nxt = {new_st, bus.mem_rdata[SYM_W-1:0]};
            end else begin
               state_nxt  = S_ACK;
               reject_nxt = 1'b1;
            end
         end
         S_WRITE: begin
            state_nxt    = S_ANIM;
            anim_cnt_nxt = '0;
            if (cur_op_q == OP_REMOVE && removed_cnt_q < CNT_FULL)
               removed_cnt_nxt = removed_cnt_q + CNT_W'(1);
         end
         S_ANIM: begin
            if (anim_cnt_q == ANIM_LAST) state_nxt = S_ACK;
            else                         anim_cnt_nxt = anim_cnt_q + ANIM_W'(1);
         end
         S_ACK:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase

      if (state_nxt == S_ANIM) begin
         anim_active_nxt = 1'b1;
         anim_idx_nxt    = cur_idx_nxt;
      end

      if (state_nxt == S_ACK) begin
         op_reject_nxt = reject_nxt;
         case (cur_op_nxt)
            OP_FLIP:   flip_ack_nxt   = 1'b1;
            OP_UNFLIP: unflip_ack_nxt = 1'b1;
            OP_REMOVE: remove_ack_nxt = 1'b1;
            default:   deal_ack_nxt   = 1'b1;
         endcase
      end

      all_pairs_nxt = (removed_cnt_nxt == CNT_FULL);
      busy_nxt      = (state_nxt != S_IDLE) || pend_valid_nxt;
   end

   // State, bookkeeping and output registers; reset aborts any command in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q            <= S_IDLE;
         cur_op_q           <= OP_FLIP;
         cur_idx_q          <= '0;
         reject_q           <= 1'b0;
         pend_valid_q       <= 1'b0;
         pend_op_q          <= OP_FLIP;
         pend_idx_q         <= '0;
         anim_cnt_q         <= '0;
         removed_cnt_q      <= '0;
         overflow_q         <= 1'b0;
         bus.flip_ack       <= 1'b0;
         bus.unflip_ack     <= 1'b0;
         bus.remove_ack     <= 1'b0;
         bus.deal_ack       <= 1'b0;
         bus.op_reject      <= 1'b0;
         bus.mem_addr       <= '0;
         bus.mem_we         <= 1'b0;
         bus.mem_wdata      <= '0;
         bus.anim_active    <= 1'b0;
         bus.anim_idx       <= '0;
         bus.busy           <= 1'b0;
         bus.all_pairs_done <= 1'b0;
      end else begin
         state_q            <= state_nxt;
         cur_op_q           <= cur_op_nxt;
         cur_idx_q          <= cur_idx_nxt;
         reject_q           <= reject_nxt;
         pend_valid_q       <= pend_valid_nxt;
         pend_op_q          <= pend_op_nxt;
         pend_idx_q         <= pend_idx_nxt;
         anim_cnt_q         <= anim_cnt_nxt;
         removed_cnt_q      <= removed_cnt_nxt;
         overflow_q         <= overflow_nxt;
         bus.flip_ack       <= flip_ack_nxt;
         bus.unflip_ack     <= unflip_ack_nxt;
         bus.remove_ack     <= remove_ack_nxt;
         bus.deal_ack       <= deal_ack_nxt;
         bus.op_reject      <= op_reject_nxt;
         bus.mem_addr       <= mem_addr_nxt;
         bus.mem_we         <= mem_we_nxt;
         bus.mem_wdata      <= mem_wdata_nxt;
         bus.anim_active    <= anim_active_nxt;
         bus.anim_idx       <= anim_idx_nxt;
         bus.busy           <= busy_nxt;
         bus.all_pairs_done <= all_pairs_nxt;
      end
   end

endmodule

// File: tb/tb_board_cmd_arbiter.sv
// Bench for board_cmd_arbiter: directed command table plus multi-cycle corner sequences.
module tb_board_cmd_arbiter;

   localparam int unsigned ANIM = 4;
   localparam int unsigned NC   = 16;

   localparam logic [1:0] T_FLIP   = 2'd0;
   localparam logic [1:0] T_UNFLIP = 2'd1;
   localparam logic [1:0] T_REMOVE = 2'd2;
   localparam logic [1:0] T_DEAL   = 2'd3;

   typedef struct {
      logic [1:0] op;
      logic [3:0] idx;
      logic [2:0] sym;
      logic       rej;
      logic [4:0] wd;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   board_cmd_arbiter_if bus ();

   board_cmd_arbiter #(.ANIM_CYCLES(ANIM), .N_CARDS(NC)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Synchronous single-port card-state RAM
   logic [4:0] ram [16];
   always @(posedge clk) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= ram[bus.mem_addr];
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] outs_vec();
      return 32'({bus.flip_ack, bus.unflip_ack, bus.remove_ack, bus.op_reject, bus.deal_ack,
                  bus.mem_addr, bus.mem_we, bus.mem_wdata, bus.anim_active, bus.anim_idx,
                  bus.busy, bus.cmd_overflow, bus.all_pairs_done});
   endfunction

   task automatic run_deal(input logic [3:0] idx, input logic [2:0] sym, input logic [4:0] exp_wd);
      int ack_c = -1;
      int we_c  = -1;
      logic [4:0] wd = '0;
      logic [3:0] wa = '0;
      bus.deal_idx = idx;
      bus.deal_sym = sym;
      bus.deal_req = 1'b1;
      for (int c = 1; c <= 10 && ack_c < 0; c++) begin
         tick();
         if (bus.mem_we) begin we_c = c; wd = bus.mem_wdata; wa = bus.mem_addr; end
         if (bus.deal_ack) ack_c = c;
      end
      check("deal_write_cycle", 32'(we_c), 32'(1));
      check("deal_addr", 32'(wa), 32'(idx));
      check("deal_wdata", 32'(wd), 32'(exp_wd));
      check("deal_ack_cycle", 32'(ack_c), 32'(2));
      tick();
      bus.deal_req = 1'b0;
   endtask

   task automatic run_game(input logic [1:0] op, input logic [3:0] idx, input logic exp_rej,
                           input logic [4:0] exp_wd, output int apd_c);
      int ack_c = -1;
      int we_c  = -1;
      int anim_n = 0;
      int anim_first = -1;
      logic [4:0] wd = '0;
      logic [3:0] rd_addr = '0;
      logic rej = 1'b0;
      logic busy1 = 1'b0;
      logic anim_idx_ok = 1'b1;
      logic [3:0] acks = '0;
      logic [3:0] exp_ack;
      exp_ack = (op == T_REMOVE) ? 4'b0100 : (op == T_UNFLIP) ? 4'b0010 : 4'b0001;
      apd_c = -1;
      bus.act_idx         = idx;
      bus.req_flip        = (op == T_FLIP);
      bus.req_unflip      = (op == T_UNFLIP);
      bus.req_remove_pair = (op == T_REMOVE);
      for (int c = 1; c <= 30 && ack_c < 0; c++) begin
         tick();
         if (c == 1) begin
            bus.req_flip = 1'b0; bus.req_unflip = 1'b0; bus.req_remove_pair = 1'b0;
            busy1 = bus.busy;
         end
         if (c == 2) rd_addr = bus.mem_addr;
         if (bus.mem_we) begin we_c = c; wd = bus.mem_wdata; end
         if (bus.anim_active) begin
            anim_n++;
            if (anim_first < 0) anim_first = c;
            if (bus.anim_idx != idx) anim_idx_ok = 1'b0;
         end
         if (bus.all_pairs_done && apd_c < 0) apd_c = c;
         if (bus.flip_ack | bus.unflip_ack | bus.remove_ack | bus.deal_ack) begin
            ack_c = c;
            rej   = bus.op_reject;
            acks  = {bus.deal_ack, bus.remove_ack, bus.unflip_ack, bus.flip_ack};
         end
      end
      check("busy_after_req", 32'(busy1), 32'(1));
      check("read_addr", 32'(rd_addr), 32'(idx));
      check("ack_cycle", 32'(ack_c), exp_rej ? 32'(4) : 32'(5 + ANIM));
      check("ack_kind", 32'(acks), 32'(exp_ack));
      check("op_reject", 32'(rej), 32'(exp_rej));
      if (exp_rej) begin
         check("reject_no_write", 32'(we_c), 32'(-1));
         check("reject_no_anim", 32'(anim_n), 32'(0));
      end else begin
         check("write_cycle", 32'(we_c), 32'(4));
         check("write_data", 32'(wd), 32'(exp_wd));
         check("anim_length", 32'(anim_n), 32'(ANIM));
         check("anim_start", 32'(anim_first), 32'(5));
         check("anim_idx", 32'(anim_idx_ok), 32'(1));
      end
      tick();
   endtask

   vec_t vecs [11];

   initial begin
      int apd;
      int flip_n, unflip_n, flip_c, unflip_c, ack_c, we_c, ack_n;
      int d_we_c, d_ack_c, f_we_c, f_ack_c;
      logic busy10, we13, ovf1, drop_next;
      logic [4:0] wd13, f_wd, wd;
      logic [3:0] acks;

      vecs[0]  = '{T_FLIP,   4'd5, 3'd0, 1'b0, 5'h0D};
      vecs[1]  = '{T_FLIP,   4'd5, 3'd0, 1'b1, 5'h00};
      vecs[2]  = '{T_UNFLIP, 4'd3, 3'd0, 1'b1, 5'h00};
      vecs[3]  = '{T_UNFLIP, 4'd5, 3'd0, 1'b0, 5'h05};
      vecs[4]  = '{T_REMOVE, 4'd5, 3'd0, 1'b1, 5'h00};
      vecs[5]  = '{T_FLIP,   4'd5, 3'd0, 1'b0, 5'h0D};
      vecs[6]  = '{T_REMOVE, 4'd5, 3'd0, 1'b0, 5'h15};
      vecs[7]  = '{T_FLIP,   4'd5, 3'd0, 1'b1, 5'h00};
      vecs[8]  = '{T_DEAL,   4'd7, 3'd6, 1'b0, 5'h06};
      vecs[9]  = '{T_FLIP,   4'd7, 3'd0, 1'b0, 5'h0E};
      vecs[10] = '{T_UNFLIP, 4'd7, 3'd0, 1'b0, 5'h06};

      reset = 1'b1;
      bus.req_flip = 1'b0; bus.req_unflip = 1'b0; bus.req_remove_pair = 1'b0;
      bus.act_idx = '0; bus.deal_req = 1'b0; bus.deal_idx = '0; bus.deal_sym = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", outs_vec(), 32'(0));
      reset = 1'b0;
      tick();
      check("idle_outputs", outs_vec(), 32'(0));

      // deal the whole board
      for (int i = 0; i < 16; i++) run_deal(4'(i), 3'(i), {2'b00, 3'(i)});
      for (int i = 0; i < 16; i++) check("ram_after_deal", 32'(ram[i]), 32'({2'b00, 3'(i)}));
      check("apd_after_deal", 32'(bus.all_pairs_done), 32'(0));

      // command table
      for (int v = 0; v < 11; v++) begin
         if (vecs[v].op == T_DEAL) run_deal(vecs[v].idx, vecs[v].sym, vecs[v].wd);
         else run_game(vecs[v].op, vecs[v].idx, vecs[v].rej, vecs[v].wd, apd);
      end
      check("ram5_removed", 32'(ram[5]), 32'(5'h15));
      check("ram7_hidden", 32'(ram[7]), 32'(5'h06));

      // redeal, then flip and remove every card
      for (int i = 0; i < 16; i++) run_deal(4'(i), 3'(i), {2'b00, 3'(i)});
      for (int i = 0; i < 16; i++) begin
         if (i == 15) check("apd_before_last", 32'(bus.all_pairs_done), 32'(0));
         run_game(T_FLIP, 4'(i), 1'b0, {2'b01, 3'(i)}, apd);
         run_game(T_REMOVE, 4'(i), 1'b0, {2'b10, 3'(i)}, apd);
         if (i == 15) check("apd_rise_cycle", 32'(apd), 32'(5));
      end
      check("apd_high", 32'(bus.all_pairs_done), 32'(1));
      run_deal(4'd0, 3'd0, 5'h00);
      check("apd_cleared_by_deal0", 32'(bus.all_pairs_done), 32'(0));

      // queued unflip during animation, third request overflows
      run_deal(4'd1, 3'd1, 5'h01);
      check("overflow_clear", 32'(bus.cmd_overflow), 32'(0));
      flip_n = 0; unflip_n = 0; flip_c = -1; unflip_c = -1;
      busy10 = 1'b0; we13 = 1'b0; wd13 = '1;
      bus.act_idx = 4'd0; bus.req_flip = 1'b1;
      for (int c = 1; c <= 30; c++) begin
         tick();
         if (c == 1) bus.req_flip = 1'b0;
         if (c == 6) begin bus.req_unflip = 1'b1; bus.act_idx = 4'd0; end
         if (c == 7) begin bus.req_unflip = 1'b0; bus.req_flip = 1'b1; bus.act_idx = 4'd1; end
         if (c == 8) bus.req_flip = 1'b0;
         if (bus.flip_ack)   begin flip_n++;   flip_c = c;   end
         if (bus.unflip_ack) begin unflip_n++; unflip_c = c; end
         if (c == 10) busy10 = bus.busy;
         if (c == 13) begin we13 = bus.mem_we; wd13 = bus.mem_wdata; end
      end
      check("conc_flip_ack_cycle", 32'(flip_c), 32'(9));
      check("conc_flip_ack_count", 32'(flip_n), 32'(1));
      check("conc_unflip_ack_cycle", 32'(unflip_c), 32'(18));
      check("conc_unflip_ack_count", 32'(unflip_n), 32'(1));
      check("conc_busy_idle_pending", 32'(busy10), 32'(1));
      check("conc_unflip_we", 32'(we13), 32'(1));
      check("conc_unflip_wdata", 32'(wd13), 32'(5'h00));
      check("conc_overflow", 32'(bus.cmd_overflow), 32'(1));
      check("conc_dropped_card", 32'(ram[1]), 32'(5'h01));

      // deal served ahead of a pending game command
      d_we_c = -1; d_ack_c = -1; f_we_c = -1; f_ack_c = -1; f_wd = '0; drop_next = 1'b0;
      bus.act_idx = 4'd1; bus.req_flip = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         tick();
         if (c == 1) begin
            bus.req_flip = 1'b0;
            bus.deal_idx = 4'd2; bus.deal_sym = 3'd3; bus.deal_req = 1'b1;
         end
         if (drop_next) begin bus.deal_req = 1'b0; drop_next = 1'b0; end
         if (bus.mem_we && bus.mem_addr == 4'd2 && d_we_c < 0) d_we_c = c;
         if (bus.mem_we && bus.mem_addr == 4'd1) begin f_we_c = c; f_wd = bus.mem_wdata; end
         if (bus.deal_ack) begin d_ack_c = c; drop_next = 1'b1; end
         if (bus.flip_ack) f_ack_c = c;
      end
      bus.deal_req = 1'b0;
      check("prio_deal_write", 32'(d_we_c), 32'(2));
      check("prio_deal_ack", 32'(d_ack_c), 32'(3));
      check("prio_flip_write", 32'(f_we_c), 32'(7));
      check("prio_flip_wdata", 32'(f_wd), 32'(5'h09));
      check("prio_flip_ack", 32'(f_ack_c), 32'(12));

      // reset in the middle of an animation
      run_deal(4'd3, 3'd3, 5'h03);
      bus.act_idx = 4'd3; bus.req_flip = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         tick();
         if (c == 1) bus.req_flip = 1'b0;
      end
      check("rst_in_anim", 32'(bus.anim_active), 32'(1));
      reset = 1'b1;
      #1;
      check("rst_outputs", outs_vec(), 32'(0));
      tick();
      reset = 1'b0;
      ack_n = 0;
      for (int c = 1; c <= 15; c++) begin
         tick();
         if (bus.flip_ack | bus.unflip_ack | bus.remove_ack | bus.deal_ack) ack_n++;
      end
      check("rst_no_ack", 32'(ack_n), 32'(0));
      check("rst_ram_kept", 32'(ram[3]), 32'(5'h0B));
      run_game(T_FLIP, 4'd3, 1'b1, 5'h00, apd);

      // simultaneous requests: remove wins, overflow flagged
      ack_c = -1; we_c = -1; wd = '0; acks = '0; ovf1 = 1'b0;
      bus.act_idx = 4'd3; bus.req_flip = 1'b1; bus.req_unflip = 1'b1; bus.req_remove_pair = 1'b1;
      for (int c = 1; c <= 20 && ack_c < 0; c++) begin
         tick();
         if (c == 1) begin
            bus.req_flip = 1'b0; bus.req_unflip = 1'b0; bus.req_remove_pair = 1'b0;
            ovf1 = bus.cmd_overflow;
         end
         if (bus.mem_we) begin we_c = c; wd = bus.mem_wdata; end
         if (bus.flip_ack | bus.unflip_ack | bus.remove_ack | bus.deal_ack) begin
            ack_c = c;
            acks = {bus.deal_ack, bus.remove_ack, bus.unflip_ack, bus.flip_ack};
         end
      end
      check("multi_overflow", 32'(ovf1), 32'(1));
      check("multi_ack_cycle", 32'(ack_c), 32'(5 + ANIM));
      check("multi_ack_kind", 32'(acks), 32'(4'b0100));
      check("multi_write_cycle", 32'(we_c), 32'(4));
      check("multi_wdata", 32'(wd), 32'(5'h13));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
